// File: rtl/pra_pkg.sv
// rtl/pra_pkg.sv - shared constants and helpers for the pipelined ripple adder
//
// Purpose : default geometry of the adder and the chunk-width helper.
// Ports   : none (package).
package pra_pkg;

   localparam int PRA_WIDTH  = 16;
   localparam int PRA_STAGES = 4;

   // Bits handled by one pipeline stage.
   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational ripple-carry chunk
//
// Purpose : W-bit ripple-carry adder used as one pipeline stage's arithmetic.
// Ports   : a, b   - W-bit addends
//           cin    - carry into bit 0
//           sum    - W-bit sum
//           cout   - carry out of bit W-1
module rca_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[W];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - valid/ready pipelined ripple-carry adder/subtractor
//
// Purpose : adds (a + b + cin) or subtracts (a - b) over STAGES pipeline
//           stages, each stage rippling WIDTH/STAGES bits.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid, in_ready  - operand beat handshake
//           a, b, cin, sub      - operands, carry-in (add only), subtract select
//           out_valid, out_ready- result beat handshake
//           sum, cout           - result and raw MSB carry (1 = no borrow in sub)
//           ovf                 - signed overflow, only when PRA_OVF_EN is defined
module pipelined_ripple_adder
   import pra_pkg::*;
#(
   parameter int WIDTH  = PRA_WIDTH,
   parameter int STAGES = PRA_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PRA_OVF_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);

   localparam int CW = chunk_width(WIDTH, STAGES);
   // The last stage needs no operand skew registers.
   localparam int NQ = (STAGES > 1) ? STAGES - 1 : 1;

   logic             advance;

   // Inputs seen by each stage: stage 0 from the ports, stage k from stage k-1.
   logic [WIDTH-1:0] a_in  [STAGES];
   logic [WIDTH-1:0] b_in  [STAGES];
   logic [WIDTH-1:0] s_in  [STAGES];
   logic             c_in  [STAGES];
   logic             v_in  [STAGES];

   // Remaining operand bits are kept right-aligned so the next chunk is
   // always at bit 0; completed sum chunks accumulate in place.
   logic [WIDTH-1:0] a_q     [NQ];
   logic [WIDTH-1:0] b_q     [NQ];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             carry_q [STAGES];
   logic             valid_q [STAGES];

   logic [CW-1:0]    s_chunk [STAGES];
   logic             c_chunk [STAGES];

   assign advance  = !valid_q[STAGES-1] || out_ready;
   assign in_ready = advance && !rst;

   always_comb begin
      a_in[0] = a;
      b_in[0] = sub ? ~b : b;
      c_in[0] = sub ? 1'b1 : cin;
      s_in[0] = '0;
      v_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = carry_q[k-1];
         s_in[k] = sum_q[k-1];
         v_in[k] = valid_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      rca_slice #(.W(CW)) u_slice (
         .a    (a_in[k][CW-1:0]),
         .b    (b_in[k][CW-1:0]),
         .cin  (c_in[k]),
         .sum  (s_chunk[k]),
         .cout (c_chunk[k])
      );
   end

`ifdef PRA_OVF_EN
   logic ovf_q;
`endif

   // A stall freezes every stage at once, so bubbles and beats keep their spacing.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            sum_q[k]   <= '0;
         end
         for (int k = 0; k < NQ; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
`ifdef PRA_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= v_in[k];
            carry_q[k] <= c_chunk[k];
            sum_q[k]   <= s_in[k] | (WIDTH'(s_chunk[k]) << (CW * k));
         end
         for (int k = 0; k < STAGES - 1; k++) begin
            a_q[k] <= a_in[k] >> CW;
            b_q[k] <= b_in[k] >> CW;
         end
`ifdef PRA_OVF_EN
         // The last stage works on the top chunk, so its MSBs are the operand signs.
         ovf_q <= (a_in[STAGES-1][CW-1] == b_in[STAGES-1][CW-1]) &&
                  (s_chunk[STAGES-1][CW-1] != a_in[STAGES-1][CW-1]);
`endif
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
`ifdef PRA_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - bench for pipelined_ripple_adder (8/2 and 32/4 builds)
module tb_pipelined_ripple_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
   logic [7:0] a8, b8, sum8;

   logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32;
   logic [31:0] a32, b32, sum32;

`ifdef PRA_OVF_EN
   logic ovf8, ovf32;
`endif

   pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
`ifdef PRA_OVF_EN
      .cout(cout8), .ovf(ovf8)
`else
      .cout(cout8)
`endif
   );

   pipelined_ripple_adder #(.WIDTH(32), .STAGES(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .cin(cin32), .sub(sub32),
      .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
`ifdef PRA_OVF_EN
      .cout(cout32), .ovf(ovf32)
`else
      .cout(cout32)
`endif
   );

   int total = 0;
   int bad   = 0;
   int n_out8 = 0;
   int n_out32 = 0;
   bit rst_prev = 1'b0;

   typedef struct {
      logic [63:0] s;
      bit          co;
      bit          ov;
   } exp_t;

   exp_t q8[$];
   exp_t q32[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit values.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input bit c, input bit s);
      exp_t        r;
      logic [63:0] m, t;
      longint      sa, sb, tr, lim;
      m   = (64'd1 << w) - 64'd1;
      lim = longint'(64'd1 << (w - 1));
      sa  = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
      sb  = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
      if (s) begin
         r.s  = (a - b) & m;
         r.co = (a >= b);
         tr   = sa - sb;
      end else begin
         t    = a + b + 64'(c);
         r.s  = t & m;
         r.co = t[w];
         tr   = sa + sb + longint'(c);
      end
      r.ov = (tr >= lim) || (tr < -lim);
      return r;
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Single compare process: scoreboard both DUTs on every falling edge.
   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         q32.delete();
      end else begin
         if (rst_prev) begin
            chk("rst_out_valid8", out_valid8, 0);
            chk("rst_sum8", sum8, 0);
            chk("rst_cout8", cout8, 0);
            chk("rst_out_valid32", out_valid32, 0);
            chk("rst_sum32", sum32, 0);
            chk("rst_cout32", cout32, 0);
`ifdef PRA_OVF_EN
            chk("rst_ovf8", ovf8, 0);
            chk("rst_ovf32", ovf32, 0);
`endif
         end
         chk("in_ready8", in_ready8, !out_valid8 || out_ready8);
         chk("in_ready32", in_ready32, !out_valid32 || out_ready32);
         if (out_valid8) begin
            if (q8.size() == 0) chk("spurious_out8", out_valid8, 0);
            else begin
               chk("sum8", sum8, q8[0].s);
               chk("cout8", cout8, q8[0].co);
`ifdef PRA_OVF_EN
               chk("ovf8", ovf8, q8[0].ov);
`endif
               if (out_ready8) begin
                  void'(q8.pop_front());
                  n_out8++;
               end
            end
         end
         if (out_valid32) begin
            if (q32.size() == 0) chk("spurious_out32", out_valid32, 0);
            else begin
               chk("sum32", sum32, q32[0].s);
               chk("cout32", cout32, q32[0].co);
`ifdef PRA_OVF_EN
               chk("ovf32", ovf32, q32[0].ov);
`endif
               if (out_ready32) begin
                  void'(q32.pop_front());
                  n_out32++;
               end
            end
         end
         if (in_valid8 && in_ready8)
            q8.push_back(model(8, 64'(a8), 64'(b8), cin8, sub8));
         if (in_valid32 && in_ready32)
            q32.push_back(model(32, 64'(a32), 64'(b32), cin32, sub32));
      end
      rst_prev = rst;
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit c, input bit s);
      int n = 0;
      bit acc = 1'b0;
      a8 = a; b8 = b; cin8 = c; sub8 = s; in_valid8 = 1'b1;
      while (1) begin
         @(negedge clk);
         acc = in_ready8;
         @(posedge clk);
         #1;
         n++;
         if (acc || n >= 100) break;
      end
      in_valid8 = 1'b0;
      if (!acc) chk("send8_timeout", acc, 1);
   endtask

   // Idle pipeline, out_ready8=1: literal result exactly 2 cycles after accept.
   task automatic send_check(input logic [7:0] a, input logic [7:0] b, input bit c, input bit s,
                             input logic [7:0] want_sum, input bit want_cout, input bit want_ovf);
      send8(a, b, c, s);
      @(negedge clk);
      chk("lat_early_valid", out_valid8, 0);
      @(negedge clk);
      chk("lat_valid", out_valid8, 1);
      chk("lit_sum", sum8, want_sum);
      chk("lit_cout", cout8, want_cout);
`ifdef PRA_OVF_EN
      chk("lit_ovf", ovf8, want_ovf);
`else
      if (want_ovf) total += 0;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic drain8();
      int n = 0;
      while (q8.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain8", q8.size(), 0);
   endtask

   initial begin
      int n_before;
      int cnt, cyc, n;
      bit hs;
      rst = 1'b1;
      in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 1'b1;
      in_valid32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; out_ready32 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      send_check(8'd15, 8'd10, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0);
      send_check(8'd200, 8'd55, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
      send_check(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      send_check(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      send_check(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      send_check(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Six back-to-back beats with a 3-cycle output stall mid-stream.
      n_before = n_out8;
      out_ready8 = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready8 = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready8, 0);
            end
            @(posedge clk);
            #1 out_ready8 = 1'b1;
         end
      join
      drain8();
      chk("stall_count", n_out8 - n_before, 6);

      // Reset with two beats in flight: nothing may come out of them.
      @(posedge clk);
      #1 out_ready8 = 1'b0;
      send8(8'd1, 8'd2, 1'b0, 1'b0);
      send8(8'd3, 8'd4, 1'b0, 1'b0);
      n_before = n_out8;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready8 = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready8, 1);
      chk("post_rst_out_valid", out_valid8, 0);
      @(posedge clk);
      #1;
      send_check(8'd9, 8'd6, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0);
      chk("post_rst_count", n_out8 - n_before, 1);

      // 1000 random beats through the 32/4 build with random backpressure.
      cnt = 0; cyc = 0; hs = 1'b0;
      while (cnt < 1000 && cyc < 20000) begin
         if (!in_valid32 || hs) begin
            if ($urandom_range(0, 3) != 0) begin
               in_valid32 = 1'b1;
               a32 = pick32();
               b32 = pick32();
               cin32 = 1'($urandom);
               sub32 = 1'($urandom);
            end else begin
               in_valid32 = 1'b0;
            end
         end
         out_ready32 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         hs = in_valid32 && in_ready32;
         if (hs) cnt++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid32 = 1'b0;
      out_ready32 = 1'b1;
      n = 0;
      while (q32.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("rand_budget", cyc < 20000, 1);
      chk("drain32", q32.size(), 0);
      chk("beats32", n_out32, 1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
